// File: rtl/muller_c_seq.sv
// Four-phase handshake sequencer exercising an external Muller C-element; c_out is 2-flop synchronized.
// Optional hold check enabled by defining MULLER_SEQ_HOLD_CHECK_EN (aborts with err_code=10).
module muller_c_seq #(
    parameter int SKEW    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] num_cycles,
    output logic       c_a,
    output logic       c_b,
    input  logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code,
    output logic [7:0] cycle_cnt
);

    typedef enum logic [2:0] {IDLE, A_UP, WAIT_HI, A_DN, WAIT_LO} state_t;

    localparam logic [7:0] SKEW_M1    = 8'(SKEW - 1);
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_TMO    = 2'b01;
`ifdef MULLER_SEQ_HOLD_CHECK_EN
    localparam logic [1:0] ERR_HOLD   = 2'b10;
`endif

    state_t     state, state_n;
    logic       c_meta, c_sync;
    logic [7:0] tmr, tmr_n;
    logic [7:0] target, target_n;
    logic [7:0] cnt_n;
    logic [1:0] err_n;
    logic       done_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_meta    <= 1'b0;
            c_sync    <= 1'b0;
            state     <= IDLE;
            tmr       <= 8'd0;
            target    <= 8'd0;
            cycle_cnt <= 8'd0;
            err_code  <= ERR_NONE;
            done      <= 1'b0;
        end else begin
            c_meta    <= c_out;
            c_sync    <= c_meta;
            state     <= state_n;
            tmr       <= tmr_n;
            target    <= target_n;
            cycle_cnt <= cnt_n;
            err_code  <= err_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        tmr_n    = tmr + 8'd1;
        target_n = target;
        cnt_n    = cycle_cnt;
        err_n    = err_code;
        done_n   = 1'b0;
        c_a      = 1'b0;
        c_b      = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy  = 1'b0;
                tmr_n = 8'd0;
                if (start) begin
                    target_n = num_cycles;
                    cnt_n    = 8'd0;
                    err_n    = ERR_NONE;
                    if (num_cycles == 8'd0) done_n  = 1'b1;
                    else                    state_n = A_UP;
                end
            end
            A_UP: begin
                c_a = 1'b1;
                if (tmr == SKEW_M1) begin
                    state_n = WAIT_HI;
                    tmr_n   = 8'd0;
                end
`ifdef MULLER_SEQ_HOLD_CHECK_EN
                // first two clocks cover synchronizer latency of the previous phase
                if (tmr >= 8'd2 && c_sync) begin
                    state_n = IDLE;
                    tmr_n   = 8'd0;
                    err_n   = ERR_HOLD;
                end
`endif
            end
            WAIT_HI: begin
                c_a = 1'b1;
                c_b = 1'b1;
                if (c_sync) begin
                    state_n = A_DN;
                    tmr_n   = 8'd0;
                end else if (tmr == TIMEOUT_M1) begin
                    state_n = IDLE;
                    tmr_n   = 8'd0;
                    err_n   = ERR_TMO;
                end
            end
            A_DN: begin
                c_b = 1'b1;
                if (tmr == SKEW_M1) begin
                    state_n = WAIT_LO;
                    tmr_n   = 8'd0;
                end
`ifdef MULLER_SEQ_HOLD_CHECK_EN
                if (tmr >= 8'd2 && !c_sync) begin
                    state_n = IDLE;
                    tmr_n   = 8'd0;
                    err_n   = ERR_HOLD;
                end
`endif
            end
            WAIT_LO: begin
                if (!c_sync) begin
                    cnt_n = cycle_cnt + 8'd1;
                    tmr_n = 8'd0;
                    if (cnt_n == target) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = A_UP;
                    end
                end else if (tmr == TIMEOUT_M1) begin
                    state_n = IDLE;
                    tmr_n   = 8'd0;
                    err_n   = ERR_TMO;
                end
            end
            default: begin
                state_n = IDLE;
                tmr_n   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_muller_c_seq.sv
// Directed/randomized bench for muller_c_seq with C-element environment models and a timing model.
module tb_muller_c_seq;

    localparam int SKEW    = 2;
    localparam int TIMEOUT = 15;
    localparam int SKEW2   = 4;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       start, start2;
    logic [7:0] num_cycles, num_cycles2;
    logic       c_a, c_b, c_out, busy, done;
    logic [1:0] err_code;
    logic [7:0] cycle_cnt;
    logic       c_a2, c_b2, c_out2, busy2, done2;
    logic [1:0] err_code2;
    logic [7:0] cycle_cnt2;

    int checks = 0;
    int errors = 0;
    int cmode  = 0;   // 0 ideal C-element, 1 output tied 0, 2 output tied 1
    int sel    = 0;   // 0 main DUT, 1 SKEW=4 DUT driven by an OR gate

    logic c_el = 1'b0;
    always @(negedge clock) if (c_a == c_b) c_el <= c_a;
    assign c_out  = (cmode == 0) ? c_el : (cmode == 2);
    assign c_out2 = c_a2 | c_b2;

    muller_c_seq #(.SKEW(SKEW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .num_cycles(num_cycles),
        .c_a(c_a), .c_b(c_b), .c_out(c_out), .busy(busy), .done(done),
        .err_code(err_code), .cycle_cnt(cycle_cnt)
    );

    muller_c_seq #(.SKEW(SKEW2), .TIMEOUT(TIMEOUT)) dut_or (
        .clock(clock), .reset_n(reset_n), .start(start2), .num_cycles(num_cycles2),
        .c_a(c_a2), .c_b(c_b2), .c_out(c_out2), .busy(busy2), .done(done2),
        .err_code(err_code2), .cycle_cnt(cycle_cnt2)
    );

    logic       m_busy, m_done, m_ca;
    assign m_busy = sel ? busy2 : busy;
    assign m_done = sel ? done2 : done;
    assign m_ca   = sel ? c_a2  : c_a;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launches a run and observes it at negedges until the DUT has been idle for 3 clocks.
    task automatic run(input int n, input int restart_at, input int budget,
                       output int busy_len, output int done_cnt, output int done_idx,
                       output int ca_rises);
        int  idle;
        logic prev;
        busy_len = 0; done_cnt = 0; done_idx = -1; ca_rises = 0; idle = 0; prev = 1'b0;
        @(negedge clock);
        if (sel != 0) begin start2 = 1'b1; num_cycles2 = 8'(n); end
        else          begin start  = 1'b1; num_cycles  = 8'(n); end
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            start = 1'b0; start2 = 1'b0;
            if (i == restart_at) begin start = 1'b1; num_cycles = 8'd9; end
            if (m_busy) busy_len++;
            if (m_done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (m_ca && !prev) ca_rises++;
            prev = m_ca;
            if (!m_busy) idle++; else idle = 0;
            if (idle == 3) break;
        end
        check("run_terminates", (idle >= 3) ? 1 : 0, 1);
    endtask

    task automatic ideal_run(input string tag, input int n, input int restart_at);
        int bl, dc, di, cr, exp_len;
        exp_len = n * (2 * SKEW + 6);
        run(n, restart_at, exp_len + 50, bl, dc, di, cr);
        check({tag, "_busy_len"}, bl, exp_len);
        check({tag, "_done_cnt"}, dc, 1);
        check({tag, "_done_idx"}, di, exp_len);
        check({tag, "_ca_rises"}, cr, n);
        check({tag, "_cycle_cnt"}, int'(cycle_cnt), n);
        check({tag, "_err"}, int'(err_code), 0);
        check({tag, "_idle_drv"}, int'({c_a, c_b}), 0);
    endtask

    initial begin
        int bl, dc, di, cr, n, k;
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
        num_cycles = 8'd0; num_cycles2 = 8'd0;
        repeat (3) @(negedge clock);
        check("reset_outputs", int'({c_a, c_b, busy, done, err_code, cycle_cnt}), 0);
        check("reset_outputs_or", int'({c_a2, c_b2, busy2, done2, err_code2, cycle_cnt2}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // zero-length run: done one clock after start, never busy
        run(0, -1, 20, bl, dc, di, cr);
        check("zero_busy_len", bl, 0);
        check("zero_done_idx", di, 0);
        check("zero_done_cnt", dc, 1);
        check("zero_cycle_cnt", int'(cycle_cnt), 0);

        ideal_run("ideal3", 3, -1);
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 12);
            ideal_run("rand", n, -1);
        end
        ideal_run("max255", 255, -1);

        // c_out stuck low: WAIT_HI times out
        cmode = 1;
        repeat (3) @(negedge clock);
        run(1, -1, 100, bl, dc, di, cr);
        check("tmo_hi_busy_len", bl, SKEW + TIMEOUT);
        check("tmo_hi_done_cnt", dc, 0);
        check("tmo_hi_err", int'(err_code), 1);
        check("tmo_hi_cycle_cnt", int'(cycle_cnt), 0);
        check("tmo_hi_idle_drv", int'({c_a, c_b}), 0);

        // c_out stuck high: WAIT_HI passes on its first clock, WAIT_LO times out
        cmode = 2;
        repeat (3) @(negedge clock);
        run(2, -1, 100, bl, dc, di, cr);
        check("tmo_lo_busy_len", bl, SKEW + 1 + SKEW + TIMEOUT);
        check("tmo_lo_done_cnt", dc, 0);
        check("tmo_lo_err", int'(err_code), 1);
        check("tmo_lo_cycle_cnt", int'(cycle_cnt), 0);
        repeat (5) @(negedge clock);
        check("err_sticky", int'(err_code), 1);

        cmode = 0;
        repeat (3) @(negedge clock);
        run(0, -1, 20, bl, dc, di, cr);
        check("err_cleared_by_start", int'(err_code), 0);

        // start with num_cycles=9 during a run of 2 must be ignored
        ideal_run("restart_ignored", 2, 5);

        // asynchronous reset in WAIT_HI of the second cycle
        @(negedge clock);
        start = 1'b1; num_cycles = 8'd3;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(cycle_cnt == 8'd1 && c_a && c_b) && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("reach_wait_hi_cycle2", (k < 200) ? 1 : 0, 1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", int'({c_a, c_b, busy, done, err_code, cycle_cnt}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset_idle", int'(busy), 0);
        ideal_run("after_reset", 2, -1);

        // OR-gate C-element on the SKEW=4 instance
        sel = 1;
        run(1, -1, 100, bl, dc, di, cr);
`ifdef MULLER_SEQ_HOLD_CHECK_EN
        check("hold_busy_len", bl, 3);
        check("hold_err", int'(err_code2), 2);
        check("hold_done_cnt", dc, 0);
        check("hold_cycle_cnt", int'(cycle_cnt2), 0);
        check("hold_idle_drv", int'({c_a2, c_b2}), 0);
`else
        check("or_busy_len", bl, SKEW2 + 1 + SKEW2 + 3);
        check("or_err", int'(err_code2), 0);
        check("or_done_cnt", dc, 1);
        check("or_cycle_cnt", int'(cycle_cnt2), 1);
`endif
        sel = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muller_c_seq.md
MULLER_C_SEQ -- requirements
Module: muller_c_seq

Interface
REQ-001 SHALL have parameter SKEW, default 2, meaning clocks one C-element input leads the other (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max clocks to wait for the C-element output to follow (1..255).
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a run; sampled only in IDLE.
REQ-006 SHALL have port num_cycles  input  8  four-phase cycles per run, captured on accepted start.
REQ-007 SHALL have port c_a  output  1  drive to C-element input A.
REQ-008 SHALL have port c_b  output  1  drive to C-element input B.
REQ-009 SHALL have port c_out  input  1  C-element output, asynchronous to clock.
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port done  output  1  one-clock pulse on successful run completion.
REQ-012 SHALL have port err_code  output  2  00 none, 01 timeout, 10 premature output toggle; sticky until next accepted start.
REQ-013 SHALL have port cycle_cnt  output  8  completed cycles in current/last run.

Function
REQ-014 SHALL synchronize c_out through two flops (c_sync); all decisions use c_sync.
REQ-015 SHALL implement FSM states IDLE, A_UP, WAIT_HI, A_DN, WAIT_LO.
REQ-016 IDLE: c_a=c_b=0, busy=0; start=1 -> capture num_cycles, clear cycle_cnt and err_code; if captured value 0 -> done=1 next clock, stay IDLE; else -> A_UP.
REQ-017 A_UP: c_a=1, c_b=0 for exactly SKEW clocks, then -> WAIT_HI.
REQ-018 WAIT_HI: c_a=c_b=1; c_sync=1 -> A_DN; TIMEOUT clocks without it -> abort with err_code=01.
REQ-019 A_DN: c_a=0, c_b=1 for exactly SKEW clocks, then -> WAIT_LO.
REQ-020 WAIT_LO: c_a=c_b=0; c_sync=0 -> cycle_cnt+1; if new count equals captured num_cycles -> done=1, IDLE; else -> A_UP. TIMEOUT expiry -> abort, err_code=01.
REQ-021 Timeout counter SHALL clear on every entry to WAIT_HI/WAIT_LO; expiry means counter reaches TIMEOUT while still waiting.
REQ-022 Abort SHALL: go to IDLE next clock, drive c_a=c_b=0, busy=0, no done pulse, cycle_cnt frozen.
REQ-023 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored and SHALL NOT re-capture num_cycles.
REQ-024 cycle_cnt SHALL not wrap: max run 255 cycles; num_cycles=255 completes with cycle_cnt=255.
REQ-025 If c_sync satisfies the wait condition on the first clock of WAIT_HI/WAIT_LO, transition SHALL occur that clock (no minimum wait).

Reset
REQ-026 reset_n low SHALL immediately force IDLE, c_a=0, c_b=0, busy=0, done=0, err_code=00, cycle_cnt=0, synchronizer flops=0, counters=0, regardless of state.
REQ-027 Reset deassertion mid-handshake SHALL resume only from IDLE; no partial run is continued.

Configuration
REQ-028 With MULLER_SEQ_HOLD_CHECK_EN defined: in A_UP c_sync must stay 0 and in A_DN c_sync must stay 1 (ignoring first 2 clocks of each state for synchronizer latency); violation -> abort with err_code=10.
REQ-029 Without MULLER_SEQ_HOLD_CHECK_EN: no hold check, err_code=10 never produced, A_UP/A_DN timing unchanged.

Verification
REQ-030 Ideal C-element model, num_cycles=3, SKEW=2 -> done pulse once, cycle_cnt=3, err_code=00, c_a/c_b show 3 full four-phase sequences, busy low after done.
REQ-031 c_out tied 0, num_cycles=1 -> abort after TIMEOUT=15 clocks in WAIT_HI, err_code=01, no done, cycle_cnt=0.
REQ-032 Hold check on, c_out follows c_a only (OR gate), SKEW=4 -> err_code=10 during first A_UP, c_a=c_b=0 next clock.
REQ-033 start with num_cycles=0 -> done pulse one clock later, busy never 1, cycle_cnt=0.
REQ-034 reset_n pulsed low in WAIT_HI of cycle 2 -> all outputs zero asynchronously; new start with num_cycles=2 completes with cycle_cnt=2.
REQ-035 start re-asserted with num_cycles=9 during a run of 2 -> ignored; run ends with cycle_cnt=2 and single done.
